game_uart_tx: RTL and testbench

Serial transmitter for the guessing side of the letter game: accepts ASCII guess letters from the player-input logic, buffers them in a small FIFO, and serialises each one onto a UART line LSB-first. It is the far-end counterpart of the host-side receiver/game-register path, which consumes `msg`/`ready`. Non-letter bytes are rejected at the input so the host only ever sees `A`–`Z`.

---
 rtl/game_uart_pkg.sv | 31 +++
 rtl/game_uart_tx_if.sv | 18 +
 rtl/game_tx_fifo.sv | 73 +++++++
 rtl/game_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_game_uart_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/game_uart_pkg.sv
// ---------------------------------------------------------------------------
// game_uart_pkg
// Shared definitions for the letter-game UART path (transmitter and the
// host-side receiver both import this package).
//   tx_state_t        : transmitter FSM states. ST_PARITY only exists when
//                       GAME_UART_TX_PARITY_EN is defined.
//   ASCII_A / ASCII_Z : bounds of the only bytes allowed on the line.
//   CLKS_PER_BIT_DEF  : default baud divider.
//   is_letter()       : true for an upper-case ASCII letter.
// ---------------------------------------------------------------------------
package game_uart_pkg;

    localparam logic [7:0] ASCII_A          = 8'h41;
    localparam logic [7:0] ASCII_Z          = 8'h5A;
    localparam int         CLKS_PER_BIT_DEF = 1250;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef GAME_UART_TX_PARITY_EN
        , ST_PARITY
`endif
    } tx_state_t;

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= ASCII_A) && (b <= ASCII_Z);
    endfunction

endpackage

// File: rtl/game_uart_tx_if.sv
// ---------------------------------------------------------------------------
// game_uart_tx_if
// Byte handshake between the player-input logic and the transmitter.
//   tx_data  : ASCII byte to send
//   tx_valid : tx_data is valid
//   tx_ready : transmitter FIFO has room; a byte moves on valid & ready
// Modports: master = byte producer, slave = game_uart_tx.
// ---------------------------------------------------------------------------
interface game_uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/game_tx_fifo.sv
// ---------------------------------------------------------------------------
// game_tx_fifo
// Circular byte FIFO feeding the UART serialiser.
//   clk, nRst : clock, asynchronous active-low reset
//   push, din : write din when push is high and the FIFO is not full
//   pop, dout : dout shows the oldest entry; pop discards it (ignored if empty)
//   full      : registered, occupancy == DEPTH
//   empty     : registered, occupancy == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module game_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count_q,
    // so stale contents are never observable and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/game_uart_tx.sv
// ---------------------------------------------------------------------------
// game_uart_tx
// UART transmitter for the guessing side of the letter game. Upper-case
// letters arriving on the handshake are queued and sent LSB-first as 8N1
// frames; any other byte is dropped and flagged.
//   clk, nRst : clock, asynchronous active-low reset
//   bus       : game_uart_tx_if.slave (tx_data, tx_valid, tx_ready)
//   tx        : serial line, idles high
//   tx_busy   : frame in progress or bytes queued
//   tx_done   : one-cycle pulse on the last cycle of each stop bit
//   tx_err    : one-cycle pulse after a non-letter byte is handshaken
// Optional feature: define GAME_UART_TX_PARITY_EN to append an even parity
// bit after D7 (8E1, 11-bit frame).
// Every output comes from a flop; tx lags the FSM state by one cycle.
// ---------------------------------------------------------------------------
module game_uart_tx
    import game_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DEPTH        = 4
) (
    input  logic           clk,
    input  logic           nRst,
    game_uart_tx_if.slave  bus,
    output logic           tx,
    output logic           tx_busy,
    output logic           tx_done,
    output logic           tx_err
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, err_q;
`ifdef GAME_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       fifo_full, fifo_empty, push, pop, bad_byte, last_tick;
    logic [7:0] fifo_dout;

    // Handshake qualification uses only the registered full flag, so
    // tx_ready never depends on tx_data.
    assign push     = bus.tx_valid & ~fifo_full &  is_letter(bus.tx_data);
    assign bad_byte = bus.tx_valid & ~fifo_full & ~is_letter(bus.tx_data);

    game_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (push),
        .pop   (pop),
        .din   (bus.tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign last_tick = (baud_q == BAUD_LAST);

    // NOTE: every variable driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        done_d   = 1'b0;
        pop      = 1'b0;
`ifdef GAME_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
`ifdef GAME_UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (last_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (last_tick) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef GAME_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef GAME_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (last_tick) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (last_tick) begin
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef GAME_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            // Whenever the FSM is (or stays) idle there is no pop this edge,
            // so the queue is non-empty afterwards iff it was or a push lands.
            busy_q   <= (state_d != ST_IDLE) | push | ~fifo_empty;
            err_q    <= bad_byte;
`ifdef GAME_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx_ready = ~fifo_full;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_game_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_game_uart_tx
// Directed and random stimulus for game_uart_tx with CLKS_PER_BIT = 8 and
// DEPTH = 4. The reference model is a frame schedule: each accepted letter is
// popped one edge after the transmitter becomes free (a frame occupies FRAME
// edges after its pop, plus one idle cycle), and the expected line level,
// busy, ready, done and err for every cycle follow from that schedule.
// ---------------------------------------------------------------------------
module tb_game_uart_tx;
    import game_uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef GAME_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic nRst;
    logic tx, tx_busy, tx_done, tx_err;

    game_uart_tx_if bus ();

    game_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .nRst    (nRst),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int         k;            // edges since reset release
    logic [7:0] fifo_m [$];   // queued, not yet popped
    logic [7:0] cur_byte;     // byte of the most recent frame
    int         cur_p;        // edge at which it was popped
    int         next_pop_ok;  // first edge at which a pop may happen
    logic       err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef GAME_UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        k           = 0;
        fifo_m.delete();
        cur_byte    = 8'h00;
        cur_p       = -100000;
        next_pop_ok = 0;
        err_m       = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic rdy, letter, do_pop;
        k++;
        rdy    = (fifo_m.size() < DEPTH);
        letter = (d >= 8'h41) && (d <= 8'h5A);
        do_pop = (k >= next_pop_ok) && (fifo_m.size() > 0);
        if (do_pop) begin
            cur_byte    = fifo_m.pop_front();
            cur_p       = k;
            next_pop_ok = k + FRAME + 1;
        end
        if (v && rdy && letter) fifo_m.push_back(d);
        err_m = v && rdy && !letter;
    endtask

    task automatic check_outputs();
        int   off;
        logic e_tx;
        off  = k - (cur_p + 1);
        e_tx = (off >= 0 && off < FRAME) ? exp_bit(cur_byte, off / CPB) : 1'b1;
        check("tx", 32'(tx), 32'(e_tx));
        check("tx_ready", 32'(bus.tx_ready), 32'(fifo_m.size() < DEPTH));
        check("tx_busy", 32'(tx_busy),
              32'(((k >= cur_p) && (k < cur_p + FRAME)) || (fifo_m.size() > 0)));
        check("tx_done", 32'(tx_done), 32'(k == cur_p + FRAME));
        check("tx_err", 32'(tx_err), 32'(err_m));
    endtask

    // Called at a falling edge: drive, advance the model, check after the edge.
    task automatic cycle(input logic v, input logic [7:0] d);
        bus.tx_valid = v;
        bus.tx_data  = d;
        model_edge(v, d);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((fifo_m.size() > 0 || k < cur_p + FRAME + 1) && guard < 3000) begin
            cycle(1'b0, 8'($urandom));
            guard++;
        end
        check("drain_bound", 32'(guard < 3000), 32'd1);
        idle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},    32'(tx),           32'd1);
        check({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
        check({tag, "_busy"},  32'(tx_busy),      32'd0);
        check({tag, "_done"},  32'(tx_done),      32'd0);
        check({tag, "_err"},   32'(tx_err),       32'd0);
    endtask

    initial begin
        logic [7:0] burst [5];
        logic       rdy_before;
        int         guard;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        nRst = 1'b1;
        #1 nRst = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
        check_outputs();

        // Single 'O', then single 'M' (parity 0 when enabled).
        cycle(1'b1, 8'h4F);
        drain();
        cycle(1'b1, 8'h4D);
        drain();

        // Back-to-back burst fills the FIFO while the first frame runs.
        burst = '{8'h4F, 8'h50, 8'h4D, 8'h4D, 8'h52};
        foreach (burst[i]) cycle(1'b1, burst[i]);

        // Hold a letter against a full FIFO until a pop frees a slot.
        guard = 0;
        do begin
            rdy_before = (fifo_m.size() < DEPTH);
            cycle(1'b1, 8'h5A);
            guard++;
        end while (!rdy_before && guard < 500);
        check("hold_bound", 32'(guard < 500), 32'd1);
        check("hold_waited", 32'(guard > 1), 32'd1);
        drain();

        // Rejected bytes: lower-case, space, and the neighbours of the range.
        cycle(1'b1, 8'h61);
        cycle(1'b0, 8'h41);
        cycle(1'b1, 8'h20);
        cycle(1'b1, 8'h40);
        cycle(1'b1, 8'h5B);
        cycle(1'b1, 8'h41);
        cycle(1'b1, 8'h5A);
        drain();

        // Random mix of letters and arbitrary bytes.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else                           d = 8'(8'h41 + $urandom_range(0, 25));
            cycle(1'($urandom_range(0, 1)), d);
        end
        drain();

        // Reset in the middle of a frame with more bytes queued.
        cycle(1'b1, 8'h4F);
        cycle(1'b1, 8'h50);
        cycle(1'b1, 8'h4D);
        idle(30);
        bus.tx_valid = 1'b0;
        #2 nRst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        nRst = 1'b1;
        model_reset();
        check_outputs();
        idle(5);
        cycle(1'b1, 8'h4F);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
